tcbm_device_port: RTL and testbench
===================================

// Module: tcbm_device_port
// PURPOSE
//  Device (drive) end of the TCBM link, facing the host-side 6523 TIA
//  (PA data, PB status, PC DAV/ACK). Decodes the host code byte, runs the
//  DAV/ACK handshake, and moves one byte per transaction to/from the drive core.
//  Sits between the paddle cable pins and the SD-side drive controller.
// PARAMETERS
//  SYNC_STAGES  2      flops on dav_in / pa_in before use (min 2)
//  TIMEOUT_W    16     width of host-wait timeout counter; timeout at all-ones
// PORTS
//  clock      in   1  single clock, all logic rising-edge
//  reset      in   1  synchronous, active-high
//  pa_in      in   8  TIA port A as seen at device pins
//  pa_out     out  8  byte driven to port A when pa_oe=1
//  pa_oe      out  1  port A output enable (pad tristate control)
//  st_out     out  2  status lines to TIA port B[1:0]
//  dav_in     in   1  host data-valid strobe (TIA PC), active low, async
//  ack_out    out  1  device acknowledge (TIA PC), active low
//  cmd_code   out  2  decoded code: 0=$81 CMD 1=$82 WR 2=$83 RD 3=$84 REL
//  rx_valid   out  1  rx_data/cmd_code valid (write-type codes)
//  rx_data    out  8  byte received from host
//  rx_ready   in   1  core accepts rx byte
//  rx_status  in   2  status returned for write-type codes, sampled at accept
//  tx_req     out  1  host asked for a byte ($83)
//  tx_valid   in   1  core supplies byte
//  tx_data    in   8  byte to host
//  tx_status  in   2  status returned with tx byte (01=EOI, 10=timeout...)
//  timeout    out  1  one-cycle pulse: host stalled, FSM aborted
// BEHAVIOUR
//  Reset: ack_out=1, pa_oe=0, pa_out=0, st_out=0, rx_valid=0, tx_req=0,
//   timeout=0, cmd_code=0, rx_data=0; FSM=IDLE; sync chains preset 1 / 0xFF.
//  dav_s = dav_in after SYNC_STAGES; edges detected on dav_s only. pa sampled
//   via same-depth synchroniser, latched only 1 cycle after the dav_s edge.
//  States:
//   IDLE: ack_out=1, pa_oe=0. dav_s 1->0 -> CODE.
//   CODE: latch pa. $81/$82/$83/$84 -> cmd_code, ack_out=0, -> WAIT_DATA.
//    Other values: no ACK, -> IGNORE (wait dav_s=1 then IDLE).
//   WAIT_DATA: wait dav_s 0->1. RD -> TX_WAIT (tx_req=1).
//    CMD/WR/REL: latch pa into rx_data (REL latches 0), rx_valid=1 -> RX_HOLD.
//   RX_HOLD: rx_valid held until rx_valid&rx_ready; that cycle st_out<=rx_status,
//    rx_valid<=0, ack_out<=1 -> IDLE.
//   TX_WAIT: tx_req=1 until tx_valid; then pa_out<=tx_data, pa_oe<=1,
//    st_out<=tx_status, tx_req<=0 and, one cycle later (bus settle), ack_out<=1
//    -> TX_HOLD.
//   TX_HOLD: host reads, then dav_s 1->0 -> pa_oe=0, ack_out=0 -> TX_END.
//   TX_END: dav_s 0->1 -> ack_out=1 -> IDLE.
//  Latency: ACK edge follows host DAV edge by SYNC_STAGES+2 clocks, except
//   where core wait (rx_ready/tx_valid) extends it.
//  Timeout counter clears on every state change; increments in WAIT_DATA,
//   TX_HOLD, TX_END, IGNORE (host-side waits only, never core waits). At
//   all-ones: timeout pulse, pa_oe=0, ack_out=1, rx_valid=0, tx_req=0, -> IDLE.
//  st_out holds last value until next accept; cleared only by reset.
//  pa_oe never asserts outside TX_HOLD (bus contention guard).
//  dav_s glitch (edge seen in wrong state) ignored; no state change.
//  reset mid-transaction: all outputs to reset values next edge, ACK released.
// STRUCTURE
//  Package tcbm_pkg: code constants 8'h81..8'h84, cmd_code encodings,
//   status encodings (ST_OK=0, ST_EOI=1, ST_TMO=2), FSM state localparams.
//  Sub-module tcbm_sync (parameterised width/depth/reset value) used for dav
//   and pa. Remainder: single FSM + timeout counter in this file.
// TESTING
//  Host WR: code $82, DAV low, data $5A, DAV high, rx_ready=1, rx_status=00
//   -> rx_data=$5A cmd_code=1, ACK low then high, st_out=00.
//  Host RD: code $83, tx_data=$C3 tx_status=01 after 10-cycle stall
//   -> tx_req held, pa_oe=1 pa_out=$C3 st_out=01, ACK=1; DAV low->pa_oe=0.
//  Bad code $7F with DAV low -> ack_out stays 1, no rx_valid, returns IDLE.
//  Host stops after code ($81, DAV stays low), TIMEOUT_W=4 -> timeout pulse
//   after 15 cycles, ack_out=1, FSM IDLE; next $82 transaction succeeds.
//  Core backpressure: rx_ready low 50 cycles -> ACK high only after accept,
//   no timeout pulse.
//  reset asserted in TX_HOLD -> next cycle pa_oe=0, ack_out=1, st_out=0.

Source files
------------

// File: rtl/tcbm_pkg.sv
// Shared constants and types for the TCBM device-side port.
// Host code bytes, core command encodings, status values, FSM states.
package tcbm_pkg;

    localparam logic [7:0] CODE_CMD = 8'h81;
    localparam logic [7:0] CODE_WR  = 8'h82;
    localparam logic [7:0] CODE_RD  = 8'h83;
    localparam logic [7:0] CODE_REL = 8'h84;

    localparam logic [1:0] CMD_CMD = 2'd0;
    localparam logic [1:0] CMD_WR  = 2'd1;
    localparam logic [1:0] CMD_RD  = 2'd2;
    localparam logic [1:0] CMD_REL = 2'd3;

    localparam logic [1:0] ST_OK  = 2'd0;
    localparam logic [1:0] ST_EOI = 2'd1;
    localparam logic [1:0] ST_TMO = 2'd2;

    typedef enum logic [2:0] {
        S_IDLE,
        S_CODE,
        S_WAIT_DATA,
        S_RX_HOLD,
        S_TX_WAIT,
        S_TX_HOLD,
        S_TX_END,
        S_IGNORE
    } state_t;

    typedef struct packed {
        logic       ok;
        logic [1:0] cmd;
    } code_t;

    function automatic code_t decode_code(input logic [7:0] b);
        code_t r;
        r.ok  = 1'b0;
        r.cmd = CMD_CMD;
        unique case (1'b1)
            (b == CODE_CMD): begin r.ok = 1'b1; r.cmd = CMD_CMD; end
            (b == CODE_WR):  begin r.ok = 1'b1; r.cmd = CMD_WR;  end
            (b == CODE_RD):  begin r.ok = 1'b1; r.cmd = CMD_RD;  end
            (b == CODE_REL): begin r.ok = 1'b1; r.cmd = CMD_REL; end
            default: ;
        endcase
        return r;
    endfunction

endpackage

// File: rtl/tcbm_device_port_if.sv
// Core-side byte handshake between the TCBM port and the drive controller.
// master = link port, slave = drive core.
interface tcbm_device_port_if;

    logic [1:0] cmd_code;
    logic       rx_valid;
    logic [7:0] rx_data;
    logic       rx_ready;
    logic [1:0] rx_status;
    logic       tx_req;
    logic       tx_valid;
    logic [7:0] tx_data;
    logic [1:0] tx_status;

    modport master (
        output cmd_code, rx_valid, rx_data, tx_req,
        input  rx_ready, rx_status, tx_valid, tx_data, tx_status
    );

    modport slave (
        input  cmd_code, rx_valid, rx_data, tx_req,
        output rx_ready, rx_status, tx_valid, tx_data, tx_status
    );

endinterface

// File: rtl/tcbm_sync.sv
// Multi-flop synchroniser with a selectable reset value.
// DEPTH must be at least 2.
module tcbm_sync #(
    parameter int             W       = 1,
    parameter int             DEPTH   = 2,
    parameter logic [W-1:0]   RST_VAL = '0
) (
    input  logic         clock,
    input  logic         reset,
    input  logic [W-1:0] d,
    output logic [W-1:0] q
);

    logic [W-1:0] ff [DEPTH];

    always_ff @(posedge clock) begin
        if (reset) begin
            for (int i = 0; i < DEPTH; i++) ff[i] <= RST_VAL;
        end else begin
            ff[0] <= d;
            for (int i = 1; i < DEPTH; i++) ff[i] <= ff[i-1];
        end
    end

    assign q = ff[DEPTH-1];

endmodule

// File: rtl/tcbm_device_port.sv
// Device end of the TCBM link: code decode, DAV/ACK handshake,
// one byte per transaction to/from the drive core, host-wait timeout.
module tcbm_device_port
    import tcbm_pkg::*;
#(
    parameter int SYNC_STAGES = 2,
    parameter int TIMEOUT_W   = 16
) (
    input  logic       clock,
    input  logic       reset,
    input  logic [7:0] pa_in,
    output logic [7:0] pa_out,
    output logic       pa_oe,
    output logic [1:0] st_out,
    input  logic       dav_in,
    output logic       ack_out,
    output logic       timeout,
    tcbm_device_port_if.master core
);

    logic       dav_s, dav_q, fall_d, rise_d;
    logic [7:0] pa_s;
    logic       dav_fall, dav_rise, waiting;
    code_t      dec;

    state_t               state, state_n;
    logic [TIMEOUT_W-1:0] cnt, cnt_n;
    logic                 ack_n, pa_oe_n, tmo_n;
    logic                 rx_valid_q, rx_valid_n, tx_req_q, tx_req_n;
    logic [7:0]           pa_out_n, rx_data_q, rx_data_n;
    logic [1:0]           st_n, cmd_q, cmd_n;

    tcbm_sync #(.W(1), .DEPTH(SYNC_STAGES), .RST_VAL(1'b1)) u_dav_sync (
        .clock(clock), .reset(reset), .d(dav_in), .q(dav_s)
    );

    tcbm_sync #(.W(8), .DEPTH(SYNC_STAGES), .RST_VAL(8'hFF)) u_pa_sync (
        .clock(clock), .reset(reset), .d(pa_in), .q(pa_s)
    );

    assign dav_fall = dav_q & ~dav_s;
    assign dav_rise = ~dav_q & dav_s;
    assign dec      = decode_code(pa_s);
    assign waiting  = state inside {S_WAIT_DATA, S_TX_HOLD, S_TX_END, S_IGNORE};

    // Read-phase edges use the delayed strobe so every ACK edge lands
    // the same number of clocks after the host DAV edge.
    always_comb begin
        state_n    = state;
        ack_n      = ack_out;
        pa_oe_n    = pa_oe;
        pa_out_n   = pa_out;
        st_n       = st_out;
        tmo_n      = 1'b0;
        cmd_n      = cmd_q;
        rx_valid_n = rx_valid_q;
        rx_data_n  = rx_data_q;
        tx_req_n   = tx_req_q;
        unique case (state)
            S_IDLE: begin
                ack_n   = 1'b1;
                pa_oe_n = 1'b0;
                if (dav_fall) state_n = S_CODE;
            end
            S_CODE: begin
                if (dec.ok) begin
                    cmd_n   = dec.cmd;
                    ack_n   = 1'b0;
                    state_n = S_WAIT_DATA;
                end else begin
                    state_n = S_IGNORE;
                end
            end
            S_WAIT_DATA: begin
                if (dav_rise) begin
                    if (cmd_q == CMD_RD) begin
                        tx_req_n = 1'b1;
                        state_n  = S_TX_WAIT;
                    end else begin
                        rx_data_n  = (cmd_q == CMD_REL) ? 8'h00 : pa_s;
                        rx_valid_n = 1'b1;
                        state_n    = S_RX_HOLD;
                    end
                end
            end
            S_RX_HOLD: begin
                if (core.rx_ready) begin
                    st_n       = core.rx_status;
                    rx_valid_n = 1'b0;
                    ack_n      = 1'b1;
                    state_n    = S_IDLE;
                end
            end
            S_TX_WAIT: begin
                if (core.tx_valid) begin
                    pa_out_n = core.tx_data;
                    pa_oe_n  = 1'b1;
                    st_n     = core.tx_status;
                    tx_req_n = 1'b0;
                    state_n  = S_TX_HOLD;
                end
            end
            S_TX_HOLD: begin
                if (!ack_out) begin
                    ack_n = 1'b1;
                end else if (fall_d) begin
                    pa_oe_n = 1'b0;
                    ack_n   = 1'b0;
                    state_n = S_TX_END;
                end
            end
            S_TX_END: begin
                if (rise_d) begin
                    ack_n   = 1'b1;
                    state_n = S_IDLE;
                end
            end
            S_IGNORE: begin
                if (dav_s) state_n = S_IDLE;
            end
            default: state_n = S_IDLE;
        endcase
        if (waiting && cnt == '1) begin
            tmo_n      = 1'b1;
            pa_oe_n    = 1'b0;
            ack_n      = 1'b1;
            rx_valid_n = 1'b0;
            tx_req_n   = 1'b0;
            state_n    = S_IDLE;
        end
        if (state_n != state) cnt_n = '0;
        else if (waiting)     cnt_n = cnt + 1'b1;
        else                  cnt_n = cnt;
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state      <= S_IDLE;
            cnt        <= '0;
            dav_q      <= 1'b1;
            fall_d     <= 1'b0;
            rise_d     <= 1'b0;
            ack_out    <= 1'b1;
            pa_oe      <= 1'b0;
            pa_out     <= 8'h00;
            st_out     <= ST_OK;
            timeout    <= 1'b0;
            cmd_q      <= CMD_CMD;
            rx_valid_q <= 1'b0;
            rx_data_q  <= 8'h00;
            tx_req_q   <= 1'b0;
        end else begin
            state      <= state_n;
            cnt        <= cnt_n;
            dav_q      <= dav_s;
            fall_d     <= dav_fall;
            rise_d     <= dav_rise;
            ack_out    <= ack_n;
            pa_oe      <= pa_oe_n;
            pa_out     <= pa_out_n;
            st_out     <= st_n;
            timeout    <= tmo_n;
            cmd_q      <= cmd_n;
            rx_valid_q <= rx_valid_n;
            rx_data_q  <= rx_data_n;
            tx_req_q   <= tx_req_n;
        end
    end

    assign core.cmd_code = cmd_q;
    assign core.rx_valid = rx_valid_q;
    assign core.rx_data  = rx_data_q;
    assign core.tx_req   = tx_req_q;

endmodule

// File: tb/tb_tcbm_device_port.sv
// Directed bench for tcbm_device_port: host-side DAV sequencing plus a
// scoreboard of bytes the core should receive.
module tb_tcbm_device_port;

    logic       clock = 1'b0;
    logic       reset;
    logic [7:0] pa_in;
    logic [7:0] pa_out;
    logic       pa_oe;
    logic [1:0] st_out;
    logic       dav_in;
    logic       ack_out;
    logic       timeout;

    int         n_chk = 0;
    int         n_pass = 0;
    int         tmo_seen = 0;
    logic [9:0] sb [$];
    logic [9:0] sb_exp;

    tcbm_device_port_if core_if ();

    tcbm_device_port #(
        .SYNC_STAGES(2),
        .TIMEOUT_W(4)
    ) dut (
        .clock(clock),
        .reset(reset),
        .pa_in(pa_in),
        .pa_out(pa_out),
        .pa_oe(pa_oe),
        .st_out(st_out),
        .dav_in(dav_in),
        .ack_out(ack_out),
        .timeout(timeout),
        .core(core_if)
    );

    always #5 clock = ~clock;

    task automatic check(input string tag, input logic [31:0] obs,
                         input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic wait_ack(input logic v, input int budget,
                            input string tag, output int n);
        n = 0;
        while (ack_out !== v && n < budget) begin
            tick();
            n++;
        end
        check(tag, 32'(ack_out), 32'(v));
    endtask

    // Core accept monitor: every accepted byte must match the scoreboard.
    always @(negedge clock) begin
        if (!reset && core_if.rx_valid && core_if.rx_ready) begin
            if (sb.size() == 0) begin
                check("sb_extra", 32'(sb.size()), 32'd1);
            end else begin
                sb_exp = sb.pop_front();
                check("rx_word", 32'({core_if.cmd_code, core_if.rx_data}),
                      32'(sb_exp));
            end
        end
        if (timeout) tmo_seen++;
    end

    // Write-type transaction; ACK latency 4 = two sync flops + two clocks.
    task automatic host_write(input logic [7:0] code, input logic [7:0] data,
                              input logic [1:0] status, input int hold);
        int         n;
        logic [1:0] c;
        c = code[1:0] - 2'd1;
        sb.push_back({c, (code == 8'h84) ? 8'h00 : data});
        pa_in  = code;
        dav_in = 1'b0;
        wait_ack(1'b0, 12, "code_ack", n);
        check("code_lat", 32'(n), 32'd4);
        check("cmd_code", 32'(core_if.cmd_code), 32'(c));
        pa_in  = data;
        dav_in = 1'b1;
        n = 0;
        while (!core_if.rx_valid && n < 12) begin
            tick();
            n++;
        end
        check("rx_valid", 32'(core_if.rx_valid), 32'd1);
        check("rx_lat", 32'(n), 32'd3);
        repeat (hold) tick();
        check("ack_held", 32'(ack_out), 32'd0);
        core_if.rx_status = status;
        core_if.rx_ready  = 1'b1;
        wait_ack(1'b1, 4, "data_ack", n);
        core_if.rx_ready = 1'b0;
        check("st_out_wr", 32'(st_out), 32'(status));
        check("rx_drop", 32'(core_if.rx_valid), 32'd0);
    endtask

    // Read transaction up to the point where the device drives the bus.
    task automatic read_to_hold(input logic [7:0] data, input logic [1:0] status,
                                input int stall);
        int n;
        pa_in  = 8'h83;
        dav_in = 1'b0;
        wait_ack(1'b0, 12, "rd_code_ack", n);
        check("rd_cmd", 32'(core_if.cmd_code), 32'd2);
        pa_in  = 8'h00;
        dav_in = 1'b1;
        n = 0;
        while (!core_if.tx_req && n < 12) begin
            tick();
            n++;
        end
        check("tx_req", 32'(core_if.tx_req), 32'd1);
        check("tx_lat", 32'(n), 32'd3);
        repeat (stall) tick();
        check("tx_stall", 32'({core_if.tx_req, pa_oe, ack_out}), 32'b100);
        core_if.tx_data   = data;
        core_if.tx_status = status;
        core_if.tx_valid  = 1'b1;
        tick();
        core_if.tx_valid = 1'b0;
        check("tx_drive", 32'({pa_oe, pa_out, st_out, core_if.tx_req, ack_out}),
              32'({1'b1, data, status, 1'b0, 1'b0}));
        tick();
        check("tx_ack", 32'({ack_out, pa_oe}), 32'b11);
    endtask

    initial begin
        int   n;
        int   tmo_base;
        logic lo, rv;
        reset             = 1'b1;
        dav_in            = 1'b1;
        pa_in             = 8'h00;
        core_if.rx_ready  = 1'b0;
        core_if.rx_status = 2'b00;
        core_if.tx_valid  = 1'b0;
        core_if.tx_data   = 8'h00;
        core_if.tx_status = 2'b00;
        repeat (3) tick();
        check("reset_state",
              32'({ack_out, pa_oe, pa_out, st_out, core_if.rx_valid,
                   core_if.tx_req, timeout, core_if.cmd_code, core_if.rx_data}),
              32'({1'b1, 1'b0, 8'h00, 2'b00, 1'b0, 1'b0, 1'b0, 2'b00, 8'h00}));
        reset = 1'b0;
        repeat (4) tick();

        host_write(8'h82, 8'h5A, 2'b00, 0);
        repeat (3) tick();

        read_to_hold(8'hC3, 2'b01, 10);
        dav_in = 1'b0;
        wait_ack(1'b0, 8, "rd_end_ack", n);
        check("rd_end_lat", 32'(n), 32'd4);
        check("rd_end_oe", 32'(pa_oe), 32'd0);
        dav_in = 1'b1;
        wait_ack(1'b1, 8, "rd_rel_ack", n);
        check("rd_rel_lat", 32'(n), 32'd4);
        check("st_hold", 32'(st_out), 32'd1);
        repeat (3) tick();

        pa_in  = 8'h7F;
        dav_in = 1'b0;
        lo = 1'b0;
        rv = 1'b0;
        repeat (10) begin
            tick();
            if (!ack_out) lo = 1'b1;
            if (core_if.rx_valid) rv = 1'b1;
        end
        check("bad_noack", 32'(lo), 32'd0);
        check("bad_norx", 32'(rv), 32'd0);
        dav_in = 1'b1;
        repeat (5) tick();
        check("no_tmo_yet", 32'(tmo_seen), 32'd0);

        // 15 increments reach all-ones, the abort registers one clock later.
        tmo_base = tmo_seen;
        pa_in  = 8'h81;
        dav_in = 1'b0;
        wait_ack(1'b0, 12, "tmo_code_ack", n);
        n = 0;
        while (!timeout && n < 40) begin
            tick();
            n++;
        end
        check("tmo_pulse", 32'(timeout), 32'd1);
        check("tmo_lat", 32'(n), 32'd16);
        check("tmo_ack", 32'({ack_out, pa_oe, core_if.rx_valid}), 32'b100);
        tick();
        check("tmo_once", 32'(timeout), 32'd0);
        dav_in = 1'b1;
        repeat (4) tick();
        host_write(8'h82, 8'h96, 2'b01, 0);
        check("tmo_count", 32'(tmo_seen - tmo_base), 32'd1);
        repeat (3) tick();

        host_write(8'h81, 8'h3C, 2'b11, 50);
        check("bp_no_tmo", 32'(tmo_seen - tmo_base), 32'd1);
        repeat (3) tick();

        host_write(8'h84, 8'hAA, 2'b10, 2);
        repeat (3) tick();

        read_to_hold(8'h11, 2'b10, 2);
        reset = 1'b1;
        tick();
        check("rst_mid",
              32'({pa_oe, ack_out, st_out, pa_out, core_if.tx_req}),
              32'({1'b0, 1'b1, 2'b00, 8'h00, 1'b0}));
        reset  = 1'b0;
        dav_in = 1'b1;
        repeat (4) tick();

        check("sb_empty", 32'(sb.size()), 32'd0);
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: bench did not complete");
        $fatal(1, "watchdog");
    end

endmodule
